// File: rtl/fpga_cfg_pkg.sv
// Shared types and CRC-8 helper for the configuration loader.
package fpga_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_CRCW,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  // MSB-first CRC-8 over one full byte.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/fpga_cfg_pclk_gen.sv
// prog_clk generator: PCLK_DIV cycles low, PCLK_DIV cycles high, while run is held.
module fpga_cfg_pclk_gen #(
  parameter int PCLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic prog_clk,
  output logic bit_tick
);

  localparam int CW = $clog2(PCLK_DIV + 1);

  logic [CW-1:0] cnt;
  logic          last;

  assign last     = (cnt == CW'(PCLK_DIV - 1));
  // Fires on the cycle whose edge returns prog_clk low: the shift point.
  assign bit_tick = run && prog_clk && last;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      prog_clk <= 1'b0;
    end else if (!run) begin
      cnt      <= '0;
      prog_clk <= 1'b0;
    end else if (last) begin
      cnt      <= '0;
      prog_clk <= ~prog_clk;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fpga_cfg_loader.sv
// Byte-stream to configuration-chain loader with trailing CRC-8 check.
module fpga_cfg_loader
  import fpga_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = 12,
  parameter int PCLK_DIV  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic       prog_clk,
  output logic       ccff_head,
  output logic       busy,
  output logic       done,
  output logic       crc_err,
  output logic       fabric_rst_n
);

  localparam int NBYTES = (CHAIN_LEN + 7) / 8;
  localparam int PAD    = NBYTES * 8 - CHAIN_LEN;
  localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_t         state;
  logic [7:0]     shreg;
  logic [7:0]     crc;
  logic [BCW-1:0] byte_cnt;
  logic [3:0]     bit_cnt;
  logic           run;
  logic           bit_tick;
  logic           first_byte;
  logic [7:0]     load_byte;
  logic [3:0]     load_bits;

  // Byte 0 is pre-shifted so its PAD leading bits never reach the chain.
  assign first_byte = (byte_cnt == '0);
  assign load_byte  = first_byte ? 8'(s_data << PAD) : s_data;
  assign load_bits  = first_byte ? 4'(8 - PAD) : 4'd8;
  assign run        = (state == ST_SHIFT) && !abort;

  fpga_cfg_pclk_gen #(.PCLK_DIV(PCLK_DIV)) u_pclk_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .prog_clk (prog_clk),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset too, so nothing observable is ever X after reset.
      state        <= ST_IDLE;
      shreg        <= '0;
      crc          <= '0;
      byte_cnt     <= '0;
      bit_cnt      <= '0;
      s_ready      <= 1'b0;
      ccff_head    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      crc_err      <= 1'b0;
      fabric_rst_n <= 1'b0;
    end else if (abort && (state == ST_LOAD || state == ST_SHIFT || state == ST_CRCW)) begin
      state        <= ST_IDLE;
      s_ready      <= 1'b0;
      ccff_head    <= 1'b0;
      busy         <= 1'b0;
      fabric_rst_n <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state        <= ST_LOAD;
            s_ready      <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            crc_err      <= 1'b0;
            fabric_rst_n <= 1'b0;
            crc          <= CRC8_INIT;
            byte_cnt     <= '0;
            bit_cnt      <= '0;
          end
        end
        ST_LOAD: begin
          if (s_valid && s_ready) begin
            shreg     <= load_byte;
            ccff_head <= load_byte[7];
            crc       <= crc8_byte(crc, s_data);
            bit_cnt   <= load_bits;
            s_ready   <= 1'b0;
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (bit_tick) begin
            shreg     <= shreg << 1;
            ccff_head <= shreg[6];
            bit_cnt   <= bit_cnt - 1'b1;
            if (bit_cnt == 4'd1) begin
              s_ready <= 1'b1;
              if (byte_cnt == BCW'(NBYTES - 1)) begin
                state <= ST_CRCW;
              end else begin
                byte_cnt <= byte_cnt + 1'b1;
                state    <= ST_LOAD;
              end
            end
          end
        end
        ST_CRCW: begin
          if (s_valid && s_ready) begin
            s_ready <= 1'b0;
            busy    <= 1'b0;
            if (s_data == crc) begin
              state        <= ST_DONE;
              done         <= 1'b1;
              fabric_rst_n <= 1'b1;
            end else begin
              state   <= ST_ERROR;
              crc_err <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fpga_cfg_loader.md
Name: fpga_cfg_loader

Overview:
- Configuration controller for the fpga_top fabric. Accepts a byte-wide bitstream through a valid/ready handshake and serialises it MSB-first into the configuration chain (ccff_head), generating prog_clk from clk.
- Checks a trailing CRC-8 byte against the streamed data.
- Releases the fabric reset only after a full, CRC-clean load.
- Sits between the pin-level wrapper (ui_in bytes / host strobes) and fpga_top.

Parameters:
- CHAIN_LEN, 12, number of configuration flip-flops in the chain (≥1).
- PCLK_DIV, 2, prog_clk half-period in clk cycles (≥1).
- Derived NBYTES = ceil(CHAIN_LEN/8).
- Derived PAD = NBYTES*8 − CHAIN_LEN.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a load.
- abort  in  1  level; cancels a load in progress.
- s_data  in  8  bitstream byte.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader accepts a byte this cycle.
- prog_clk  out  1  configuration chain clock, registered.
- ccff_head  out  1  configuration chain serial data, registered.
- busy  out  1  load in progress.
- done  out  1  last load succeeded; sticky until next start.
- crc_err  out  1  last load failed CRC; sticky until next start.
- fabric_rst_n  out  1  active-low fabric reset; high only in DONE.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values:
  - State = IDLE.
  - s_ready, prog_clk, ccff_head, busy, done, crc_err, fabric_rst_n all 0.
  - Byte counter, bit counter and CRC register all 0.
- States: IDLE, LOAD, SHIFT, CRCW, DONE, ERROR.
- IDLE/DONE/ERROR, start=1 → LOAD.
  - On this transition: clear done, crc_err, CRC (init 0x00) and counters; drive fabric_rst_n=0 and busy=1.
  - start in any other state is ignored.
- LOAD:
  - s_ready=1.
  - On s_valid&&s_ready the byte is captured into the shift register and CRC-8 is updated (poly 0x07, MSB-first, all 8 bits including pad).
  - Go to SHIFT next cycle.
  - Bits to shift = 8−PAD for byte 0, 8 for later bytes. The first PAD MSBs of byte 0 are discarded.
- SHIFT, per bit:
  - Low phase: ccff_head = current MSB, prog_clk=0, for PCLK_DIV cycles.
  - High phase: prog_clk=1 for PCLK_DIV cycles; ccff_head stable.
  - The register shifts on the cycle prog_clk returns to 0.
  - One bit = 2*PCLK_DIV clk cycles.
- After the last bit of a byte:
  - More bytes remain → LOAD.
  - Otherwise → CRCW.
  - Total rising prog_clk edges per load = CHAIN_LEN exactly.
- CRCW:
  - s_ready=1.
  - Accepted byte equal to the CRC register → DONE: done=1, fabric_rst_n=1, busy=0.
  - Otherwise → ERROR: crc_err=1, fabric_rst_n stays 0, busy=0.
- s_ready is 0 in IDLE, SHIFT, DONE and ERROR. Bytes presented then are not consumed.
- abort=1 in LOAD/SHIFT/CRCW → IDLE next cycle.
  - prog_clk=0, s_ready=0, busy=0, fabric_rst_n=0; done/crc_err stay 0.
  - abort in IDLE/DONE/ERROR has no effect.
  - abort has priority over a simultaneous handshake.
- Asynchronous reset mid-load:
  - All outputs go to reset values immediately.
  - The chain contents are undefined; a full reload is required.
- prog_clk is never high for fewer than PCLK_DIV cycles, except under rst_n or abort.

Decomposition:
- Package fpga_cfg_pkg holds:
  - the state enum;
  - CRC8_POLY=8'h07 and CRC8_INIT=8'h00;
  - a function crc8_byte(crc, data).
- One sub-module, fpga_cfg_pclk_gen, is natural: the phase counter and prog_clk/bit-tick generation, parameterised by PCLK_DIV.

Test Plan:
- Nominal load, CHAIN_LEN=12, PCLK_DIV=2:
  - Stimulus: start, then bytes 0xA5, 0x3C, CRC 0xED.
  - Required: ccff_head sampled at the 12 prog_clk rises = 0101 00111100.
  - Each bit lasts 4 clk cycles.
  - done=1, fabric_rst_n=1, crc_err=0.
- Bad CRC: same data with CRC 0xEC → ERROR, crc_err=1, fabric_rst_n=0, exactly 12 prog_clk pulses.
- Back-pressure: s_valid asserted during SHIFT → s_ready=0 and the byte is held. It is accepted in the first LOAD cycle and no bit is lost or duplicated.
- Abort: abort asserted during bit 6 while prog_clk=1 → next cycle IDLE, prog_clk=0, busy=0. A fresh start then completes the nominal load correctly.
- Async reset: rst_n low mid-SHIFT → all outputs 0 immediately. Stray start/s_valid during reset are ignored.
- Reload:
  - start from DONE clears done and drops fabric_rst_n within 1 cycle.
  - CHAIN_LEN=16 (PAD=0) loads all 16 bits, checked against the CRC-8 reference model.
